rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-port arbiter and scheduler for the 16×16-bit register file. It accepts register writebacks from two independent requesters, the ALU (port 0) and the memory unit (port 1). Each requester has a 2-entry buffer. The block grants one write per cycle using round-robin priority and drives the register file's single write port (Caddr, C, load). It drops writes to the hardwired $zero register and exports a per-register busy scoreboard that issue logic uses to stall on pending writes.

## Interface
- ADDR_W, 4, register address width (16 registers)
- DATA_W, 16, register data width
- clk  in  1  sole clock; all state updates on rising edge
- nClear  in  1  asynchronous, active-low reset
- wb0_valid  in  1  ALU write request
- wb0_ready  out  1  ALU buffer can accept
- wb0_addr  in  ADDR_W  ALU destination register
- wb0_data  in  DATA_W  ALU write data
- wb1_valid / wb1_ready / wb1_addr / wb1_data  same as port 0, memory requester
- Caddr  out  ADDR_W  register file write address (registered)
- C  out  DATA_W  register file write data (registered)
- load  out  1  register file write enable (registered)
- busy  out  16  busy[i]=1 while a write to register i is buffered or on the output stage
- drop_count  out  8  saturating count of writes dropped to address 0

## Operation
- Transfer on port n: wbn_valid & wbn_ready at a rising edge.
- wbn_ready = (buffer n count < 2). It depends only on registered state, never on valid.
- A full buffer deasserts ready even in a pop cycle. There is no pass-through.
- Address-0 transfers are accepted as normal (ready rules unchanged) but are not written to the buffer. Each one increments drop_count, saturating at 255.
  - If both ports drop in the same cycle, drop_count increments by 2, clamped at 255.
- Each buffer is 2 entries, FIFO order. Order within one requester is preserved.
- Arbiter: state is rr_pri ∈ {PRI0, PRI1}.
  - Only one buffer non-empty: grant it.
  - Both non-empty: grant the port named by rr_pri.
  - After any grant, rr_pri moves to the non-granted port.
  - No grant: rr_pri holds.
- On a grant, the head entry pops and the output stage loads Caddr/C with it and load=1. With no grant: load=0, and Caddr/C hold their last values.
- Cross-requester ordering to the same register is not guaranteed. Issue logic must use busy to avoid it.
- busy is combinational from registered state: the OR over all valid buffer entries, plus the output stage when load=1, of a one-hot decode of the address. busy[0] is always 0.

## Timing
- Reset (nClear=0, asynchronous) sets:
  - buffers empty, so wb0_ready=wb1_ready=1
  - load=0, Caddr=0, C=0
  - rr_pri=PRI0
  - drop_count=0, busy=0
- Latency: transfer at edge k → head of buffer in cycle k+1 → output stage loaded at edge k+1 → register file captures at edge k+2.
- Throughput: 1 write per cycle in aggregate. A single requester streaming alone also sustains 1 per cycle.
- Push and pop on the same buffer in the same cycle is legal when count < 2. The count is unchanged.
- Reset asserted mid-operation discards all buffered writes and the output stage. load falls immediately (asynchronously).

## Configuration
- RF_WB_SCOREBOARD_EN
  - Defined: busy is computed as specified.
  - Undefined: busy is tied to 16'h0000 and no decode logic is built. All other behaviour is identical.

## Structure
- Shared package rf_pkg holds:
  - RF_ADDR_W=4, RF_DATA_W=16, RF_NUM_REGS=16
  - RF_ZERO_ADDR=0
  - wb_entry type {addr, data}
  - rr_pri encoding (PRI0=0, PRI1=1)
- Sub-module wb_fifo2: a 2-entry FIFO with push, pop, count, head, and entry-valid/addr taps for the scoreboard. It is instantiated once per requester.

## Test plan
- Reset, then idle → wb0_ready=wb1_ready=1, load=0, busy=0, drop_count=0.
- Single ALU write {addr=3, data=16'hBEEF} at edge k → busy[3]=1 from cycle k+1; at edge k+1, Caddr=3, C=BEEF and load=1 for one cycle; busy[3]=0 after edge k+2.
- Both ports valid every cycle: port 0 writes addr 2, 4, 6, port 1 writes addr 7, 8, 9 → load grants alternate 2, 7, 4, 8, 6, 9; each port's ready drops when its buffer holds 2.
- Port 1 valid alone with 4 back-to-back writes → one load per cycle in FIFO order; ready never falls.
- Writes to addr 0 on both ports in the same cycle, then 300 more on port 0 → no load; drop_count is 2, then saturates at 255.
- Two writes buffered, output load=1, then nClear pulsed low → load=0 and busy=0 immediately; the buffered writes never appear after release.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback path.
package rf_pkg;

    localparam int RF_ADDR_W   = 4;
    localparam int RF_DATA_W   = 16;
    localparam int RF_NUM_REGS = 16;

    localparam logic [RF_ADDR_W-1:0] RF_ZERO_ADDR = '0;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        PRI0 = 1'b0,
        PRI1 = 1'b1
    } rr_pri_t;

    function automatic logic [RF_NUM_REGS-1:0] addr_onehot(input logic [RF_ADDR_W-1:0] a);
        return RF_NUM_REGS'(1) << a;
    endfunction

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry writeback FIFO; entry 0 is always the head.
// Scoreboard taps exist only when RF_WB_SCOREBOARD_EN is defined.
module wb_fifo2
    import rf_pkg::*;
(
    input  logic                clk,
    input  logic                nClear,
    input  logic                push,
    input  wb_entry_t           push_entry,
    input  logic                pop,
    output logic [1:0]          count,
    output wb_entry_t           head
`ifdef RF_WB_SCOREBOARD_EN
    ,
    output logic [1:0]                  ent_valid,
    output logic [1:0][RF_ADDR_W-1:0]   ent_addr
`endif
);

    wb_entry_t  e0_q, e0_d;
    wb_entry_t  e1_q, e1_d;
    logic [1:0] count_q, count_d;

    // Caller guarantees push only when count < 2 and pop only when count > 0.
    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        count_d = count_q;
        unique case ({push, pop})
            2'b11: begin
                if (count_q == 2'd1) begin
                    e0_d = push_entry;
                end else begin
                    e0_d = e1_q;
                    e1_d = push_entry;
                end
            end
            2'b01: begin
                e0_d    = e1_q;
                count_d = count_q - 2'd1;
            end
            2'b10: begin
                if (count_q == 2'd0) begin
                    e0_d = push_entry;
                end else begin
                    e1_d = push_entry;
                end
                count_d = count_q + 2'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= 2'd0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = e0_q;

`ifdef RF_WB_SCOREBOARD_EN
    assign ent_valid = {count_q == 2'd2, count_q != 2'd0};
    assign ent_addr  = {e1_q.addr, e0_q.addr};
`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter driving the register file write port from ALU and memory
// writeback buffers. RF_WB_SCOREBOARD_EN enables the per-register busy scoreboard.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W
) (
    input  logic              clk,
    input  logic              nClear,
    input  logic              wb0_valid,
    output logic              wb0_ready,
    input  logic [ADDR_W-1:0] wb0_addr,
    input  logic [DATA_W-1:0] wb0_data,
    input  logic              wb1_valid,
    output logic              wb1_ready,
    input  logic [ADDR_W-1:0] wb1_addr,
    input  logic [DATA_W-1:0] wb1_data,
    output logic [ADDR_W-1:0] Caddr,
    output logic [DATA_W-1:0] C,
    output logic              load,
    output logic [15:0]       busy,
    output logic [7:0]        drop_count
);

    logic [1:0] count0, count1;
    wb_entry_t  head0, head1;
    logic       acc0, acc1, drop0, drop1, push0, push1;
    logic       grant0, grant1;

    rr_pri_t           rr_pri_q, rr_pri_d;
    logic              load_q, load_d;
    logic [ADDR_W-1:0] caddr_q, caddr_d;
    logic [DATA_W-1:0] c_q, c_d;
    logic [7:0]        drop_q, drop_d;
    logic [8:0]        drop_sum;

    assign wb0_ready = (count0 != 2'd2);
    assign wb1_ready = (count1 != 2'd2);

    assign acc0  = wb0_valid & wb0_ready;
    assign acc1  = wb1_valid & wb1_ready;
    assign drop0 = acc0 & (wb0_addr == RF_ZERO_ADDR);
    assign drop1 = acc1 & (wb1_addr == RF_ZERO_ADDR);
    assign push0 = acc0 & ~drop0;
    assign push1 = acc1 & ~drop1;

`ifdef RF_WB_SCOREBOARD_EN
    logic [1:0]                ent_valid0, ent_valid1;
    logic [1:0][RF_ADDR_W-1:0] ent_addr0, ent_addr1;
`endif

    wb_fifo2 u_fifo0 (
        .clk        (clk),
        .nClear     (nClear),
        .push       (push0),
        .push_entry ('{addr: wb0_addr, data: wb0_data}),
        .pop        (grant0),
        .count      (count0),
        .head       (head0)
`ifdef RF_WB_SCOREBOARD_EN
        ,
        .ent_valid  (ent_valid0),
        .ent_addr   (ent_addr0)
`endif
    );

    wb_fifo2 u_fifo1 (
        .clk        (clk),
        .nClear     (nClear),
        .push       (push1),
        .push_entry ('{addr: wb1_addr, data: wb1_data}),
        .pop        (grant1),
        .count      (count1),
        .head       (head1)
`ifdef RF_WB_SCOREBOARD_EN
        ,
        .ent_valid  (ent_valid1),
        .ent_addr   (ent_addr1)
`endif
    );

    // Priority only matters when both buffers hold something.
    always_comb begin
        grant0   = 1'b0;
        grant1   = 1'b0;
        rr_pri_d = rr_pri_q;
        load_d   = 1'b0;
        caddr_d  = caddr_q;
        c_d      = c_q;
        if (count0 != 2'd0 && (count1 == 2'd0 || rr_pri_q == PRI0)) begin
            grant0 = 1'b1;
        end else if (count1 != 2'd0) begin
            grant1 = 1'b1;
        end
        if (grant0) begin
            rr_pri_d = PRI1;
            load_d   = 1'b1;
            caddr_d  = head0.addr;
            c_d      = head0.data;
        end else if (grant1) begin
            rr_pri_d = PRI0;
            load_d   = 1'b1;
            caddr_d  = head1.addr;
            c_d      = head1.data;
        end
    end

    always_comb begin
        drop_sum = {1'b0, drop_q} + {8'd0, drop0} + {8'd0, drop1};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            rr_pri_q <= PRI0;
            load_q   <= 1'b0;
            caddr_q  <= '0;
            c_q      <= '0;
            drop_q   <= 8'd0;
        end else begin
            rr_pri_q <= rr_pri_d;
            load_q   <= load_d;
            caddr_q  <= caddr_d;
            c_q      <= c_d;
            drop_q   <= drop_d;
        end
    end

    assign Caddr      = caddr_q;
    assign C          = c_q;
    assign load       = load_q;
    assign drop_count = drop_q;

`ifdef RF_WB_SCOREBOARD_EN
    logic [15:0] busy_c;

    always_comb begin
        busy_c = '0;
        for (int i = 0; i < 2; i++) begin
            if (ent_valid0[i]) busy_c = busy_c | addr_onehot(ent_addr0[i]);
            if (ent_valid1[i]) busy_c = busy_c | addr_onehot(ent_addr1[i]);
        end
        if (load_q) busy_c = busy_c | addr_onehot(caddr_q);
        busy_c[0] = 1'b0;
    end

    assign busy = busy_c;
`else
    assign busy = 16'h0000;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter; busy expectations follow
// RF_WB_SCOREBOARD_EN the same way the design does.
module tb_rf_wb_arbiter;

`ifdef RF_WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        nClear;
    logic        wb0_valid, wb1_valid;
    logic        wb0_ready, wb1_ready;
    logic [3:0]  wb0_addr, wb1_addr;
    logic [15:0] wb0_data, wb1_data;
    logic [3:0]  Caddr;
    logic [15:0] C;
    logic        load;
    logic [15:0] busy;
    logic [7:0]  drop_count;

    int n_chk  = 0;
    int n_fail = 0;

    rf_wb_arbiter dut (
        .clk        (clk),
        .nClear     (nClear),
        .wb0_valid  (wb0_valid),
        .wb0_ready  (wb0_ready),
        .wb0_addr   (wb0_addr),
        .wb0_data   (wb0_data),
        .wb1_valid  (wb1_valid),
        .wb1_ready  (wb1_ready),
        .wb1_addr   (wb1_addr),
        .wb1_data   (wb1_data),
        .Caddr      (Caddr),
        .C          (C),
        .load       (load),
        .busy       (busy),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_busy(input logic [15:0] v);
        return SB ? v : 16'h0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb0_valid = 1'b0; wb0_addr = 4'd0; wb0_data = 16'h0;
        wb1_valid = 1'b0; wb1_addr = 4'd0; wb1_data = 16'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        nClear = 1'b0;
        @(negedge clk);
        nClear = 1'b1;
    endtask

    initial begin
        int a0[3];
        int a1[3];
        int exp_a[6];
        int i0, i1;
        bit acc0, acc1, saw_nr0, saw_nr1, saw_load;
        logic [3:0]  got_a[$];
        logic [15:0] got_d[$];

        nClear = 1'b0;
        idle_inputs();
        #3;
        // Reset state
        check("rst_ready0", wb0_ready, 1);
        check("rst_ready1", wb1_ready, 1);
        check("rst_load", load, 0);
        check("rst_caddr", Caddr, 0);
        check("rst_c", C, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop_count, 0);
        @(negedge clk);
        nClear = 1'b1;
        tick(); tick();
        check("idle_load", load, 0);
        check("idle_ready0", wb0_ready, 1);

        // Single ALU write
        wb0_valid = 1'b1; wb0_addr = 4'd3; wb0_data = 16'hBEEF;
        tick();
        idle_inputs();
        check("single_busy_k1", busy, exp_busy(16'h0008));
        check("single_noload_k1", load, 0);
        tick();
        check("single_load", load, 1);
        check("single_caddr", Caddr, 3);
        check("single_c", C, 16'hBEEF);
        check("single_busy_out", busy, exp_busy(16'h0008));
        tick();
        check("single_load_off", load, 0);
        check("single_busy_clr", busy, 0);
        check("single_caddr_hold", Caddr, 3);

        // Both ports streaming
        do_reset();
        a0 = '{2, 4, 6};
        a1 = '{7, 8, 9};
        exp_a = '{2, 7, 4, 8, 6, 9};
        i0 = 0; i1 = 0; saw_nr0 = 0; saw_nr1 = 0;
        got_a.delete(); got_d.delete();
        for (int cyc = 0; cyc < 12; cyc++) begin
            wb0_valid = (i0 < 3);
            wb0_addr  = (i0 < 3) ? 4'(a0[i0]) : 4'd0;
            wb0_data  = 16'h1000 + 16'(wb0_addr);
            wb1_valid = (i1 < 3);
            wb1_addr  = (i1 < 3) ? 4'(a1[i1]) : 4'd0;
            wb1_data  = 16'h2000 + 16'(wb1_addr);
            if (!wb0_ready) saw_nr0 = 1;
            if (!wb1_ready) saw_nr1 = 1;
            acc0 = wb0_valid && wb0_ready;
            acc1 = wb1_valid && wb1_ready;
            tick();
            if (acc0) i0++;
            if (acc1) i1++;
            if (cyc == 0) check("both_busy_e1", busy, exp_busy(16'h0084));
            if (load) begin
                got_a.push_back(Caddr);
                got_d.push_back(C);
            end
        end
        idle_inputs();
        check("both_nloads", got_a.size(), 6);
        for (int k = 0; k < 6 && k < got_a.size(); k++) begin
            check("both_addr", got_a[k], exp_a[k]);
            check("both_data", got_d[k], (k % 2 == 0 ? 16'h1000 : 16'h2000) + 16'(exp_a[k]));
        end
        check("both_ready0_fell", saw_nr0, 1);
        check("both_ready1_fell", saw_nr1, 1);

        // Port 1 alone, back-to-back
        do_reset();
        i1 = 0; saw_nr1 = 0;
        got_a.delete(); got_d.delete();
        for (int cyc = 0; cyc < 8; cyc++) begin
            wb1_valid = (i1 < 4);
            wb1_addr  = 4'(10 + i1);
            wb1_data  = 16'hA000 + 16'(i1);
            if (!wb1_ready) saw_nr1 = 1;
            acc1 = wb1_valid && wb1_ready;
            tick();
            if (acc1) i1++;
            if (load) begin
                got_a.push_back(Caddr);
                got_d.push_back(C);
            end
            if (cyc >= 1 && cyc <= 4) check("p1_load_each_cycle", load, 1);
        end
        idle_inputs();
        check("p1_ready_never_fell", saw_nr1, 0);
        check("p1_nloads", got_a.size(), 4);
        for (int k = 0; k < 4 && k < got_a.size(); k++) begin
            check("p1_addr", got_a[k], 10 + k);
            check("p1_data", got_d[k], 16'hA000 + 16'(k));
        end

        // Drops to address 0
        do_reset();
        saw_load = 0;
        wb0_valid = 1'b1; wb0_addr = 4'd0; wb0_data = 16'h1111;
        wb1_valid = 1'b1; wb1_addr = 4'd0; wb1_data = 16'h2222;
        tick();
        check("drop_both", drop_count, 2);
        check("drop_busy", busy, 0);
        wb1_valid = 1'b0;
        for (int k = 0; k < 252; k++) begin
            tick();
            if (load) saw_load = 1;
        end
        check("drop_254", drop_count, 254);
        wb1_valid = 1'b1;
        tick();
        check("drop_clamp_dual", drop_count, 255);
        wb1_valid = 1'b0;
        for (int k = 0; k < 47; k++) begin
            tick();
            if (load) saw_load = 1;
        end
        check("drop_sat", drop_count, 255);
        check("drop_no_load", saw_load, 0);
        check("drop_ready0", wb0_ready, 1);
        idle_inputs();

        // Reset asserted with writes in flight
        do_reset();
        wb0_valid = 1'b1; wb0_addr = 4'd5; wb0_data = 16'h0505;
        wb1_valid = 1'b1; wb1_addr = 4'd9; wb1_data = 16'h0909;
        tick();
        wb1_valid = 1'b0;
        wb0_addr = 4'd6; wb0_data = 16'h0606;
        tick();
        idle_inputs();
        check("mid_load_before", load, 1);
        check("mid_caddr_before", Caddr, 5);
        check("mid_busy_before", busy, exp_busy(16'h0260));
        #2;
        nClear = 1'b0;
        #1;
        check("mid_load_async", load, 0);
        check("mid_busy_async", busy, 0);
        check("mid_caddr_async", Caddr, 0);
        @(negedge clk);
        nClear = 1'b1;
        saw_load = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (load) saw_load = 1;
        end
        check("mid_no_replay", saw_load, 0);
        check("mid_busy_after", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
